serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_fa.sv | 17 +
 rtl/serial_adder.sv | 85 ++++++++
 tb/tb_serial_adder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder used by the serial adder.
// Purely combinational: s = x^y^cin, carry by generate/propagate.
module FullAdderStructure (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic cout,
  output logic s
);

  logic p;

  assign p    = x ^ y;
  assign s    = p ^ cin;
  assign cout = (x & y) | (p & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Operands in and result out through valid/ready handshakes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // One extra bit so WIDTH=2^k never wraps the counter.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fs;
  logic             fc;

  FullAdderStructure u_fa (sa[0], sb[0], c, fc, fs);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // FSM plus datapath: load, shift one bit per edge, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b;
            c     <= cin;
            cnt   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum <= {fs, sum[WIDTH-1:1]};
          c   <= fc;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          if (cnt == LAST) begin
            ovf   <= c ^ fc;
            cout  <= fc;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Arithmetic reference model plus directed and swept vectors.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  // Reference: plain integer addition, signed range test for ovf.
  function automatic void ref_add(input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  input logic ci,
                                  output logic [W-1:0] s,
                                  output logic co,
                                  output logic ov);
    longint u;
    longint sg;
    longint lim;
    u   = longint'(x) + longint'(y) + longint'(ci);
    s   = u[W-1:0];
    co  = u[W];
    sg  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    lim = longint'(1) << (W - 1);
    ov  = (sg > lim - 1) || (sg < -lim);
  endfunction

  // Transaction-level model: accept in idle, result after W edges,
  // held until consumed.
  int           m_phase = 0;
  int           m_left = 0;
  bit           m_fresh = 1'b1;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout;
  logic         p_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_fresh = 1'b1;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          ref_add(a, b, cin, p_sum, p_cout, p_ovf);
          m_left  = W;
          m_phase = 1;
          m_fresh = 1'b0;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_sum   = p_sum;
            m_cout  = p_cout;
            m_ovf   = p_ovf;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    if (m_phase == 2 || m_fresh) begin
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic run_op(input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic ci,
                        input bit lit,
                        input logic [W-1:0] es,
                        input logic ec,
                        input logic eo,
                        input int stall,
                        input bit toggle,
                        output time t_done);
    int n;
    logic [W-1:0] rs;
    logic rc;
    logic ro;
    ref_add(x, y, ci, rs, rc, ro);
    t_done = 0;
    n = 0;
    while (!in_ready && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      timeout("wait_idle");
      return;
    end
    if (stall > 0) out_ready = 1'b0;
    a = x;
    b = y;
    cin = ci;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
    cin = ~ci;
    n = 0;
    while (!out_valid && n < 3 * W) begin
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      timeout("wait_done");
      out_ready = 1'b1;
      return;
    end
    t_done = $time;
    chk("latency", 32'(n), 32'(W));
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(rs));
      chk("stall_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("res_sum", 32'(sum), 32'(rs));
    chk("res_cout", 32'(cout), 32'(rc));
    chk("res_ovf", 32'(ovf), 32'(ro));
    if (lit) begin
      chk("lit_sum", 32'(sum), 32'(es));
      chk("lit_cout", 32'(cout), 32'(ec));
      chk("lit_ovf", 32'(ovf), 32'(eo));
      chk("model_sum", 32'(m_sum), 32'(es));
      chk("model_ovf", 32'(m_ovf), 32'(eo));
    end
    @(posedge clk); #1;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1;
    time t2;
    int  n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h0F, 8'h01, 1'b0, 1, 8'h10, 1'b0, 1'b0, 0, 0, t1);
    run_op(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0, 0, 0, t1);
    run_op(8'h7F, 8'h00, 1'b1, 1, 8'h80, 1'b0, 1'b1, 0, 0, t1);
    run_op(8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1, 1'b0, 5, 0, t1);
    run_op(8'h80, 8'h80, 1'b0, 1, 8'h00, 1'b1, 1'b1, 0, 0, t1);

    run_op(8'h3C, 8'h42, 1'b1, 1, 8'h7F, 1'b0, 1'b0, 0, 1, t1);
    run_op(8'h01, 8'h02, 1'b0, 1, 8'h03, 1'b0, 1'b0, 0, 1, t2);
    chk("throughput", 32'((t2 - t1) / 10), 32'(W + 2));

    run_op(8'h7F, 8'h00, 1'b1, 1, 8'h80, 1'b0, 1'b1, 0, 0, t1);

    a = 8'h0F;
    b = 8'h00;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("no_valid_after_abort", 32'(n), 32'd0);
    run_op(8'h55, 8'hAA, 1'b0, 1, 8'hFF, 1'b0, 1'b0, 0, 0, t1);

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             0, '0, 1'b0, 1'b0, 0, 0, t1);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
